pwm_square_generator: RTL
=========================

// Module: pwm_square_generator
// PURPOSE
//  Programmable square-wave/PWM generator clocked from the 20.48 MHz system clock.
//  A free-running period counter gives a 50% square wave (toggle per period) or a PWM wave with programmable duty.
//  Period, duty and mode are staged through shadow registers, so changes never produce a truncated or glitched period.
//  Feeds board test points and downstream timing logic; o_period_tick gives a per-period strobe.
// PARAMETERS
//  CNT_W           11    width of counter, period and duty
//  DEFAULT_PERIOD  2047  active period after reset; 20.48 MHz / (2*2048) = 5 kHz in square mode
//  DEFAULT_DUTY    1024  active duty after reset
//  DEFAULT_MODE    0     active mode after reset: 0 = square, 1 = PWM
// PORTS
//  clock          in   1      system clock
//  reset          in   1      synchronous, active-high reset
//  i_enable       in   1      1 = run; 0 = hold counter at 0, outputs low
//  i_load         in   1      one-cycle strobe; captures i_period, i_duty, i_mode
//  i_period       in   CNT_W  P: terminal count, period = P+1 clocks
//  i_duty         in   CNT_W  D: high clocks per period (PWM mode)
//  i_mode         in   1      0 = square, 1 = PWM
//  o_signal       out  1      generated waveform, registered
//  o_period_tick  out  1      one-cycle pulse per completed period
//  o_pending      out  1      staged values not yet applied
// BEHAVIOUR
//  Reset (synchronous, active-high, on a clock edge with reset=1):
//   - cnt=0; active P/D/mode = DEFAULT_*.
//   - Shadow cleared; o_signal=0, o_period_tick=0, o_pending=0.
//   - Reset mid-period aborts the period with no tick; staged values are lost.
//  Counter, while enabled:
//   - cnt increments each clock.
//   - When cnt==P_act, next cnt=0: this is the boundary. Unsigned, CNT_W bits, no overflow (cnt never exceeds P_act).
//  o_period_tick: high for exactly the cycle after each boundary edge (cnt==0 cycle); never high while disabled.
//  Square mode:
//   - o_signal toggles on each boundary edge, giving frequency f_clk/(2*(P+1)).
//   - P=0 gives a toggle every clock (f_clk/2).
//  PWM mode:
//   - o_signal <= (cnt_next < D_act); high for the first D clocks of each period.
//   - D=0: constant 0. D>=P+1: constant 1.
//  Mode change at a boundary: PWM->square takes o_signal from the PWM rule; square->PWM uses the PWM rule on cnt=0.
//  Shadow load:
//   - i_load=1 writes the shadow registers and sets o_pending the next cycle.
//   - Another load while pending overwrites the shadow (last load wins).
//   - At the next boundary edge, active <= shadow and o_pending <= 0.
//   - If i_load coincides with a boundary edge, the new inputs go straight to active; o_pending stays 0.
//   - While i_enable=0, pending values apply on the next edge.
//  Disable: edge with i_enable=0 sets cnt=0, o_signal=0, tick=0.
//  Re-enable: first enabled cycle has cnt=0 (new period, no tick); square phase restarts low.
// CONFIGURATION
//  Macro PWM_COMPLEMENT_EN:
//   - Defined: adds output port o_signal_n (1 bit) = registered ~o_signal, forced 0 in reset and while disabled.
//   - Undefined: the port and its logic are absent; all other behaviour is identical.
// TESTING
//  1. Reset, enable=1, defaults -> o_signal toggles every 2048 clocks (5 kHz); tick every 2048 clocks.
//  2. Load P=9, D=3, mode=1 -> o_pending until boundary; then o_signal 3 high / 7 low, repeating every 10 clocks.
//  3. PWM P=9, D=0 then D=15 -> o_signal constant 0, then constant 1; tick still every 10 clocks.
//  4. Two loads in one period (D=2 then D=6) -> only D=6 applied at boundary; no intermediate period.
//  5. Load on the exact boundary cycle -> new P applies immediately, o_pending never asserts; square P=0 toggles every clock.
//  6. Disable mid-period and pulse reset mid-period -> cnt=0, o_signal=0, no tick.
//     Re-enable -> full first period; with PWM_COMPLEMENT_EN, o_signal_n tracks ~o_signal.

Source files
------------

// File: rtl/pwm_square_generator.sv
// Square-wave / PWM generator with shadow-staged period, duty and mode.
// Optional macro PWM_COMPLEMENT_EN adds the registered complement output o_signal_n.
module pwm_square_generator #(
  parameter int CNT_W          = 11,
  parameter int DEFAULT_PERIOD = 2047,
  parameter int DEFAULT_DUTY   = 1024,
  parameter bit DEFAULT_MODE   = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_enable,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_period,
  input  logic [CNT_W-1:0] i_duty,
  input  logic             i_mode,
  output logic             o_signal,
  output logic             o_period_tick,
`ifdef PWM_COMPLEMENT_EN
  output logic             o_signal_n,
`endif
  output logic             o_pending
);

  typedef enum logic {
    MODE_SQUARE = 1'b0,
    MODE_PWM    = 1'b1
  } mode_e;

  localparam logic [CNT_W-1:0] DEF_PERIOD = CNT_W'(DEFAULT_PERIOD);
  localparam logic [CNT_W-1:0] DEF_DUTY   = CNT_W'(DEFAULT_DUTY);
  localparam mode_e            DEF_MODE   = mode_e'(DEFAULT_MODE);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] period_act, duty_act;
  mode_e            mode_act;
  logic [CNT_W-1:0] period_sh, duty_sh;
  mode_e            mode_sh;

  logic             boundary;
  logic             apply_edge;
  logic [CNT_W-1:0] cnt_next;
  logic [CNT_W-1:0] period_next, duty_next;
  mode_e            mode_next;
  logic             signal_next;

  assign boundary = i_enable && (cnt == period_act);
  // A disabled edge restarts the period, so staged values may land there too.
  assign apply_edge = boundary || !i_enable;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    period_next = period_act;
    duty_next   = duty_act;
    mode_next   = mode_act;
    if (apply_edge) begin
      if (i_load) begin
        period_next = i_period;
        duty_next   = i_duty;
        mode_next   = mode_e'(i_mode);
      end else if (o_pending) begin
        period_next = period_sh;
        duty_next   = duty_sh;
        mode_next   = mode_sh;
      end
    end

    cnt_next = apply_edge ? '0 : cnt + 1'b1;

    signal_next = 1'b0;
    if (i_enable) begin
      if (mode_next == MODE_PWM) signal_next = (cnt_next < duty_next);
      else if (boundary)         signal_next = ~o_signal;
      else                       signal_next = o_signal;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt           <= '0;
      period_act    <= DEF_PERIOD;
      duty_act      <= DEF_DUTY;
      mode_act      <= DEF_MODE;
      period_sh     <= '0;
      duty_sh       <= '0;
      mode_sh       <= MODE_SQUARE;
      o_pending     <= 1'b0;
      o_signal      <= 1'b0;
      o_period_tick <= 1'b0;
    end else begin
      cnt           <= cnt_next;
      period_act    <= period_next;
      duty_act      <= duty_next;
      mode_act      <= mode_next;
      o_signal      <= signal_next;
      o_period_tick <= boundary;
      if (apply_edge) begin
        o_pending <= 1'b0;
      end else if (i_load) begin
        period_sh <= i_period;
        duty_sh   <= i_duty;
        mode_sh   <= mode_e'(i_mode);
        o_pending <= 1'b1;
      end
    end
  end

`ifdef PWM_COMPLEMENT_EN
  always_ff @(posedge clock) begin
    if (reset) o_signal_n <= 1'b0;
    else       o_signal_n <= i_enable & ~signal_next;
  end
`endif

endmodule
